// File: rtl/fwd_sel_gen.sv
// fwd_sel_gen: forwarding-select and load-use stall generator.
// Keeps a shadow of the destination registers of the instructions in EX and MEM.
// It produces registered 2-bit operand-mux selects for the instruction in EX:
//   00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
// It also raises a combinational one-cycle stall on a load-use hazard.
// The WB-stage result is not tracked. The register file writes before it reads,
// so an instruction that follows its producer by three or more slots reads the
// correct value with select 00.
// Optional feature: define FWD_STATS_EN to add the fwd_count and stall_count counters.
module fwd_sel_gen #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]       fwd_count,
    output logic [31:0]       stall_count
`endif
);

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              mem_valid;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;

    logic              ex_hit_a;
    logic              ex_hit_b;
    logic              mem_hit_a;
    logic              mem_hit_b;
    logic              bubble;
    logic [1:0]        next_a;
    logic [1:0]        next_b;

    // Decide which older in-flight instruction, if any, produces each ID source register.
    always_comb begin
        ex_hit_a  = ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == id_rs1);
        ex_hit_b  = ex_valid  & ex_regwrite  & (ex_rd  != '0) & (ex_rd  == id_rs2);
        mem_hit_a = mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == id_rs1);
        mem_hit_b = mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == id_rs2);
    end

    // Stall when a load in EX feeds the ID instruction. A flush takes priority and suppresses the stall.
    always_comb begin
        stall  = id_valid & ~flush & ex_memread & (ex_hit_a | ex_hit_b);
        bubble = stall | flush | ~id_valid;
    end

    // Pick the select values to load for the instruction entering EX. The nearer producer (EX) wins.
    always_comb begin
        next_a = 2'b00;
        next_b = 2'b00;
        if (!bubble) begin
            if (ex_hit_a)       next_a = 2'b01;
            else if (mem_hit_a) next_a = 2'b10;
            if (ex_hit_b)       next_b = 2'b01;
            else if (mem_hit_b) next_b = 2'b10;
        end
    end

    // Advance the destination shadow one stage per clock. A stall or flush inserts a bubble into EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_valid    <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
        end else begin
            mem_valid    <= ex_valid;
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            if (stall || flush) begin
                ex_valid    <= 1'b0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_rd       <= id_rd;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
            end
        end
    end

    // Register the selects so that they line up with the instruction now in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_sel <= 2'b00;
            fwd_b_sel <= 2'b00;
        end else begin
            fwd_a_sel <= next_a;
            fwd_b_sel <= next_b;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_inc;

    // Count how many of the two selects being loaded are nonzero (0, 1 or 2).
    always_comb begin
        fwd_inc = 32'(next_a != 2'b00) + 32'(next_b != 2'b00);
    end

    // Accumulate forwarded operands and stall cycles. Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            fwd_count   <= fwd_count + fwd_inc;
            stall_count <= stall_count + 32'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_sel_gen.sv
// tb_fwd_sel_gen: self-checking bench for fwd_sel_gen.
// It drives a directed vector table, a reset-during-hazard sequence and a
// randomized stream checked against a pipeline-history reference model.
module tb_fwd_sel_gen;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
`ifdef FWD_STATS_EN
    logic [31:0] fwd_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int fails  = 0;

    fwd_sel_gen #(.REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef FWD_STATS_EN
        , .fwd_count(fwd_count), .stall_count(stall_count)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       valid;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
        bit       fl;
        bit       exp_stall;
        bit [1:0] exp_a;
        bit [1:0] exp_b;
    } vec_t;

    // Reference model: the most recent instructions to enter EX, newest first (index 0 = EX, 1 = MEM)
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       rw;
        bit       mr;
    } instr_t;

    instr_t      hist[2];
    int unsigned model_fwd;
    int unsigned model_stalls;

    function automatic bit writes(instr_t e, bit [4:0] s);
        return e.valid && e.rw && (e.rd != 0) && (e.rd == s);
    endfunction

    function automatic bit model_stall(bit v, bit [4:0] r1, bit [4:0] r2, bit fl);
        return v && !fl && hist[0].mr && (writes(hist[0], r1) || writes(hist[0], r2));
    endfunction

    // Distance to the youngest in-flight producer: 1 = EX/MEM, 2 = MEM/WB, 0 = none
    function automatic bit [1:0] model_sel(bit [4:0] s);
        for (int i = 0; i < 2; i++)
            if (writes(hist[i], s)) return 2'(i + 1);
        return 2'b00;
    endfunction

    task automatic checkOutput(string name, int unsigned actual, int unsigned expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle from the falling edge. Sample stall just before the rising edge
    // and the selects just after it. The model computes its expectations and advances alongside.
    task automatic applyStimulus(input vec_t v, input bit r,
                                 output bit got_stall, output bit [1:0] got_a, output bit [1:0] got_b,
                                 output bit m_stall, output bit [1:0] m_a, output bit [1:0] m_b);
        bit bub;
        rst = r; id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_regwrite = v.rw; id_memread = v.mr; flush = v.fl;
        #1;
        got_stall = stall;
        m_stall = model_stall(v.valid, v.rs1, v.rs2, v.fl);
        bub = m_stall || v.fl || !v.valid || r;
        m_a = bub ? 2'b00 : model_sel(v.rs1);
        m_b = bub ? 2'b00 : model_sel(v.rs2);
        @(posedge clk);
        #1;
        got_a = fwd_a_sel;
        got_b = fwd_b_sel;
        if (r) begin
            hist[0] = '{default: 0};
            hist[1] = '{default: 0};
            model_fwd = 0;
            model_stalls = 0;
        end else begin
            model_fwd += (m_a != 0) + (m_b != 0);
            model_stalls += m_stall;
            hist[1] = hist[0];
            if (m_stall || v.fl) hist[0] = '{default: 0};
            else hist[0] = '{valid: v.valid, rd: v.rd, rw: v.rw, mr: v.mr};
        end
        @(negedge clk);
    endtask

    vec_t table_v[18];
    vec_t nopv;
    vec_t v;
    vec_t prev;
    bit   gs, ms;
    bit [1:0] ga, gb, ma, mb;
    bit   r;
    bit   prev_stall;

    initial begin
        nopv = '{default: 0};
        hist[0] = '{default: 0};
        hist[1] = '{default: 0};
        model_fwd = 0;
        model_stalls = 0;
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_regwrite = 0; id_memread = 0; flush = 0;

        //                 valid rs1 rs2 rd rw mr fl | stall a  b
        table_v[0]  = '{1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00};  // add x5,x1,x2
        table_v[1]  = '{1, 5, 5, 6, 1, 0, 0, 0, 2'b01, 2'b01};  // add x6,x5,x5
        table_v[2]  = '{1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00};  // add x5,x1,x2
        table_v[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};  // nop
        table_v[4]  = '{1, 5, 1, 7, 1, 0, 0, 0, 2'b10, 2'b00};  // sub x7,x5,x1
        table_v[5]  = '{1, 2, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00};  // lw x3,0(x2)
        table_v[6]  = '{1, 3, 2, 4, 1, 0, 0, 1, 2'b00, 2'b00};  // add x4,x3,x2: stall
        table_v[7]  = '{1, 3, 2, 4, 1, 0, 0, 0, 2'b10, 2'b00};  // replayed add
        table_v[8]  = '{1, 1, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00};  // add x0,x1,x1
        table_v[9]  = '{1, 0, 0, 9, 1, 0, 0, 0, 2'b00, 2'b00};  // add x9,x0,x0
        table_v[10] = '{1, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00};  // add x5,x1,x1
        table_v[11] = '{1, 2, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00};  // add x5,x2,x2
        table_v[12] = '{1, 5, 5, 8, 1, 0, 0, 0, 2'b01, 2'b01};  // add x8,x5,x5: 01 wins
        table_v[13] = '{1, 1, 1, 3, 1, 1, 0, 0, 2'b00, 2'b00};  // lw x3
        table_v[14] = '{1, 3, 2, 4, 1, 0, 1, 0, 2'b00, 2'b00};  // dependent add + flush
        table_v[15] = '{1, 3, 2, 4, 1, 0, 0, 0, 2'b10, 2'b00};  // lw now in MEM
        table_v[16] = '{1, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00};  // lw x0
        table_v[17] = '{1, 0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00};  // use x0: no stall

        @(negedge clk);
        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            applyStimulus(nopv, 1'b1, gs, ga, gb, ms, ma, mb);
            checkOutput("reset_sel_a", ga, 0);
            checkOutput("reset_sel_b", gb, 0);
        end
        rst = 1'b0;
        #1;
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_ex_clear_stall", stall, 0);

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            applyStimulus(table_v[i], 1'b0, gs, ga, gb, ms, ma, mb);
            checkOutput($sformatf("vec%0d_stall", i), gs, table_v[i].exp_stall);
            checkOutput($sformatf("vec%0d_sel_a", i), ga, table_v[i].exp_a);
            checkOutput($sformatf("vec%0d_sel_b", i), gb, table_v[i].exp_b);
        end
`ifdef FWD_STATS_EN
        checkOutput("stats_fwd_count", fwd_count, 7);
        checkOutput("stats_stall_count", stall_count, 1);
`endif

        // Reset arriving while a load-use hazard is pending discards it
        v = '{1, 2, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00};
        applyStimulus(v, 1'b0, gs, ga, gb, ms, ma, mb);
        v = '{1, 3, 3, 4, 1, 0, 0, 0, 2'b00, 2'b00};
        applyStimulus(v, 1'b1, gs, ga, gb, ms, ma, mb);
        checkOutput("midrst_sel_a", ga, 0);
        checkOutput("midrst_sel_b", gb, 0);
        applyStimulus(v, 1'b0, gs, ga, gb, ms, ma, mb);
        checkOutput("midrst_stall", gs, 0);
        checkOutput("midrst_after_a", ga, 0);
`ifdef FWD_STATS_EN
        checkOutput("midrst_stall_count", stall_count, 0);
`endif

        // Randomized stream; the ID instruction is held while a stall is being raised
        prev = nopv;
        prev_stall = 0;
        for (int n = 0; n < 400; n++) begin
            if (prev_stall) begin
                v = prev;
                v.fl = ($urandom_range(0, 9) == 0);
            end else begin
                v = nopv;
                v.valid = ($urandom_range(0, 7) != 0);
                v.rs1 = 5'($urandom_range(0, 6));
                v.rs2 = 5'($urandom_range(0, 6));
                v.rd  = 5'($urandom_range(0, 6));
                v.rw  = ($urandom_range(0, 4) != 0);
                v.mr  = v.rw && ($urandom_range(0, 2) == 0);
                v.fl  = ($urandom_range(0, 9) == 0);
            end
            r = ($urandom_range(0, 49) == 0);
            applyStimulus(v, r, gs, ga, gb, ms, ma, mb);
            if (!r) checkOutput("rand_stall", gs, ms);
            checkOutput("rand_sel_a", ga, ma);
            checkOutput("rand_sel_b", gb, mb);
            prev = v;
            prev_stall = ms && !r;
        end
`ifdef FWD_STATS_EN
        checkOutput("rand_fwd_count", fwd_count, model_fwd);
        checkOutput("rand_stall_count", stall_count, model_stalls);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
